// File: rtl/ntt_pkg.sv
// ntt_pkg: constants and the loader state type shared by the NTT
// coefficient loader, its sub-module and its bus interface.
//   WIDTH       coefficient width
//   LANES       coefficients per memory row (8 butterflies x 2 banks)
//   INPUT_WIDTH packed row width
//   ADDR_WIDTH  row address width
//   N_ROWS      rows per polynomial (256 / LANES)
//   Q           modulus; 2*Q must exceed 2**WIDTH - 1
package ntt_pkg;
  localparam int WIDTH       = 12;
  localparam int LANES       = 16;
  localparam int INPUT_WIDTH = WIDTH * LANES;
  localparam int ADDR_WIDTH  = 5;
  localparam int N_ROWS      = 16;
  localparam int Q           = 3329;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } ld_state_e;
endpackage

// File: rtl/ntt_coeff_loader_if.sv
// ntt_coeff_loader_if: groups the coefficient stream handshake and the
// row write port of the coefficient loader.
//   master modport: upstream controller / source of coefficients
//   slave  modport: the loader itself
//   start_i, coeff_i, coeff_valid_i  -> loader
//   coeff_ready_o, we_o, waddr_o, din_o, busy_o, done_o <- loader
interface ntt_coeff_loader_if #(
  parameter int WIDTH       = ntt_pkg::WIDTH,
  parameter int ADDR_WIDTH  = ntt_pkg::ADDR_WIDTH,
  parameter int INPUT_WIDTH = WIDTH * ntt_pkg::LANES
);
  logic                   start_i;
  logic [WIDTH-1:0]       coeff_i;
  logic                   coeff_valid_i;
  logic                   coeff_ready_o;
  logic                   we_o;
  logic [ADDR_WIDTH-1:0]  waddr_o;
  logic [INPUT_WIDTH-1:0] din_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    output start_i, coeff_i, coeff_valid_i,
    input  coeff_ready_o, we_o, waddr_o, din_o, busy_o, done_o
  );

  modport slave (
    input  start_i, coeff_i, coeff_valid_i,
    output coeff_ready_o, we_o, waddr_o, din_o, busy_o, done_o
  );
endinterface

// File: rtl/mod_q_csub.sv
// mod_q_csub: combinational reduction of a value in [0, 2Q) to [0, Q)
// with a single conditional subtract.
//   a_i  WIDTH-bit input, assumed < 2*Q
//   r_o  WIDTH-bit canonical residue
module mod_q_csub #(
  parameter int WIDTH = ntt_pkg::WIDTH,
  parameter int Q     = ntt_pkg::Q
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] r_o
);
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

  always_comb begin
    r_o = a_i;
    if (a_i >= Q_W) begin
      r_o = a_i - Q_W;
    end
  end
endmodule

// File: rtl/ntt_coeff_loader.sv
// ntt_coeff_loader: reduces a serial coefficient stream mod Q, packs 16
// coefficients per row and writes each full row to the NTT coefficient
// memory with an incrementing row address; pulses done after the last row.
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    slave side of ntt_coeff_loader_if (stream in, row write out)
//
// state | meaning
// IDLE  | waiting for start_i; stream not accepted
// FILL  | accepting coefficients, one per cycle, packing lanes/rows
// DONE  | last row write in flight; done pulse follows
module ntt_coeff_loader #(
  parameter int WIDTH       = ntt_pkg::WIDTH,
  parameter int INPUT_WIDTH = WIDTH * 16,
  parameter int ADDR_WIDTH  = ntt_pkg::ADDR_WIDTH,
  parameter int N_ROWS      = ntt_pkg::N_ROWS,
  parameter int Q           = ntt_pkg::Q
) (
  input logic              clk_i,
  input logic              rst_i,
  ntt_coeff_loader_if.slave bus
);
  import ntt_pkg::*;

  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(N_ROWS - 1);

  ld_state_e                   state_q, state_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic [ADDR_WIDTH-1:0]       row_q, row_d;
  logic [ADDR_WIDTH-1:0]       waddr_q, waddr_d;
  logic [LANES-1:0][WIDTH-1:0] pack_q, pack_d;
  logic [INPUT_WIDTH-1:0]      din_q, din_d;
  logic                        we_q, we_d;
  logic                        done_q, done_d;
  logic [WIDTH-1:0]            coeff_r;

  mod_q_csub #(.WIDTH(WIDTH), .Q(Q)) u_csub (
    .a_i(bus.coeff_i),
    .r_o(coeff_r)
  );

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    row_d   = row_q;
    waddr_d = waddr_q;
    pack_d  = pack_q;
    din_d   = din_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q may be high here, so a start on the done cycle is taken.
        if (bus.start_i) begin
          state_d = FILL;
          lane_d  = '0;
          row_d   = '0;
        end
      end
      FILL: begin
        if (bus.coeff_valid_i) begin
          pack_d[lane_q] = coeff_r;
          lane_d         = lane_q + 1'b1;
          if (lane_q == LANE_LAST) begin
            // pack_d already holds the 16th lane, so the row is complete.
            din_d   = pack_d;
            waddr_d = row_q;
            we_d    = 1'b1;
            row_d   = row_q + 1'b1;
            if (row_q == ROW_LAST) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lane_q  <= '0;
      row_q   <= '0;
      waddr_q <= '0;
      pack_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      row_q   <= row_d;
      waddr_q <= waddr_d;
      pack_q  <= pack_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign bus.coeff_ready_o = (state_q == FILL);
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.we_o          = we_q;
  assign bus.waddr_o       = waddr_q;
  assign bus.din_o         = din_q;
  assign bus.done_o        = done_q;
endmodule

// File: tb/tb_ntt_coeff_loader.sv
// tb_ntt_coeff_loader: scoreboard bench for ntt_coeff_loader. The stimulus
// side keeps a polynomial-level model (list of reduced coefficients, row
// number, busy/ready expectations) and pushes expected row writes and done
// pulses; a monitor pops and compares whenever the DUT strobes we_o/done_o.
module tb_ntt_coeff_loader;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  ntt_coeff_loader_if bus ();

  ntt_coeff_loader dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    int               cyc;
    int               addr;
    logic [191:0]     din;
  } we_exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  we_exp_t exp_we[$];
  int      exp_done[$];

  // reference model
  bit m_busy = 0;
  bit m_loading = 0;
  int m_busy_clr = -1;
  int m_row = 0;
  int m_vals[$];
  int n_acc = 0;

  // monitor state
  int n_we = 0;
  int n_done = 0;
  bit chk_spacing = 0;
  bit have_last = 0;
  int last_we = 0;

  logic [11:0] blut [4] = '{12'd3328, 12'd3329, 12'd4095, 12'd0};

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: model/check at the negedge, then return 1 time unit after
  // the following posedge so the caller can drive the next inputs.
  task automatic cycle();
    bit acc, st;
    logic [191:0] d;
    @(negedge clk);
    if (rst_i) begin
      m_busy = 0;
      m_loading = 0;
      m_row = 0;
      m_vals.delete();
      exp_we.delete();
      exp_done.delete();
    end else begin
      if (m_busy && cyc == m_busy_clr) m_busy = 0;
      chk("ready", bus.coeff_ready_o, m_loading);
      chk("busy", bus.busy_o, m_busy);
      acc = bus.coeff_valid_i && m_loading;
      st  = bus.start_i && !m_busy;
      if (acc) begin
        n_acc++;
        m_vals.push_back(int'(bus.coeff_i) % Q);
        if (m_vals.size() == LANES) begin
          d = '0;
          for (int k = 0; k < LANES; k++) d[k*WIDTH +: WIDTH] = 12'(m_vals[k]);
          exp_we.push_back('{cyc + 1, m_row, d});
          m_vals.delete();
          if (m_row == N_ROWS - 1) begin
            m_loading = 0;
            m_busy_clr = cyc + 2;
            exp_done.push_back(cyc + 2);
            m_row = 0;
          end else begin
            m_row++;
          end
        end
      end
      if (st) begin
        m_busy = 1;
        m_loading = 1;
        m_row = 0;
        m_vals.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    we_exp_t e;
    int dc;
    if (rst_i === 1'b0) begin
      if (bus.we_o !== 1'b0) begin
        n_we++;
        if (exp_we.size() == 0) begin
          chk("we_unexpected", bus.we_o, 1'b0);
        end else begin
          e = exp_we.pop_front();
          chk("we_cycle", cyc, e.cyc);
          chk("waddr", bus.waddr_o, e.addr);
          chk("din", bus.din_o, e.din);
          if (chk_spacing && have_last) chk("we_spacing", cyc - last_we, 16);
          last_we = cyc;
          have_last = 1;
        end
      end
      if (bus.done_o !== 1'b0) begin
        n_done++;
        if (exp_done.size() == 0) begin
          chk("done_unexpected", bus.done_o, 1'b0);
        end else begin
          dc = exp_done.pop_front();
          chk("done_cycle", cyc, dc);
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_ready", bus.coeff_ready_o, 1'b0);
    chk("rst_we", bus.we_o, 1'b0);
    chk("rst_waddr", bus.waddr_o, 0);
    chk("rst_din", bus.din_o, 0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
  endtask

  task automatic start_poly();
    bus.start_i = 1'b1;
    bus.coeff_valid_i = 1'b0;
    cycle();
    bus.start_i = 1'b0;
  endtask

  // mode 0: ramp i, mode 1: boundary values in lanes 0-3 of every 4th row,
  // otherwise uniformly random 0..4095
  task automatic feed(input int mode, input int count, input int pulse_at);
    for (int i = 0; i < count; i++) begin
      if (mode == 0) bus.coeff_i = 12'(i);
      else if (mode == 1 && (i % 64) < 4) bus.coeff_i = blut[i % 64];
      else bus.coeff_i = 12'($urandom_range(0, 4095));
      bus.coeff_valid_i = 1'b1;
      bus.start_i = (i == pulse_at);
      cycle();
    end
    bus.coeff_valid_i = 1'b0;
    bus.start_i = 1'b0;
  endtask

  initial begin
    int base;
    int guard;
    int base_we;

    rst_i = 1'b1;
    bus.start_i = 1'b0;
    bus.coeff_valid_i = 1'b0;
    bus.coeff_i = '0;
    cycle();
    cycle();
    check_reset_vals();
    rst_i = 1'b0;
    cycle();

    // back-to-back ramp 0..255
    have_last = 0;
    chk_spacing = 1;
    start_poly();
    feed(0, 256, -1);
    cycle();
    cycle();
    chk_spacing = 0;

    // valid while idle must not be accepted
    bus.coeff_valid_i = 1'b1;
    repeat (6) begin
      bus.coeff_i = 12'($urandom_range(0, 4095));
      cycle();
    end
    bus.coeff_valid_i = 1'b0;

    // reduction boundaries, start pulsed mid-fill, restart on done cycle
    start_poly();
    feed(1, 256, 100);
    cycle();
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;

    // throttled ramp: same rows as back-to-back, only timing moves
    base = n_acc;
    guard = 0;
    while ((n_acc - base) < 256 && guard < 3000) begin
      bus.coeff_valid_i = 1'($urandom_range(0, 1));
      bus.coeff_i = 12'(n_acc - base);
      cycle();
      guard++;
    end
    chk("throttle_accepts", n_acc - base, 256);
    bus.coeff_valid_i = 1'b0;
    repeat (3) cycle();

    // reset after 37 accepts
    base_we = n_we;
    start_poly();
    feed(2, 37, -1);
    rst_i = 1'b1;
    cycle();
    check_reset_vals();
    chk("rows_before_reset", n_we - base_we, 2);
    rst_i = 1'b0;
    repeat (4) cycle();
    chk("no_we_after_reset", n_we - base_we, 2);

    // restart from row 0 with random data
    start_poly();
    feed(2, 256, -1);
    repeat (3) cycle();

    chk("we_left", exp_we.size(), 0);
    chk("done_left", exp_done.size(), 0);
    chk("we_total", n_we, 66);
    chk("done_total", n_done, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntt_coeff_loader.md
Name: ntt_coeff_loader

Overview:
- Ingress stage directly upstream of the 16-bank NTT coefficient memory (8 butterfly units, banks 0-7 and 0B-7B).
- Accepts a serial stream of 12-bit coefficients over a valid/ready handshake and reduces each one to canonical form mod Q.
- Packs 16 coefficients into one 192-bit row, then writes that row into the memory as a single-cycle write with an incrementing row address.
- Signals completion once a full polynomial (N_ROWS rows) has been written.

Parameters:
- WIDTH, 12, coefficient bit width.
- INPUT_WIDTH, WIDTH*16, packed row width driven to the memory write port.
- ADDR_WIDTH, 5, row address width.
- N_ROWS, 16, rows per polynomial (256 coefficients / 16); must be <= 2**ADDR_WIDTH.
- Q, 3329, modulus; requires 2*Q > 2**WIDTH - 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  one-cycle pulse that begins loading one polynomial.
- coeff_i  in  WIDTH  input coefficient, any value 0..2**WIDTH-1.
- coeff_valid_i  in  1  coeff_i holds a valid coefficient.
- coeff_ready_o  out  1  loader accepts coeff_i this cycle.
- we_o  out  1  row write strobe to the memory.
- waddr_o  out  ADDR_WIDTH  row address for we_o.
- din_o  out  INPUT_WIDTH  packed row; lane k sits at bits [k*WIDTH +: WIDTH]; lanes 0-7 go to banks 0-7, lanes 8-15 to banks 0B-7B.
- busy_o  out  1  high from start acceptance until the done pulse.
- done_o  out  1  one-cycle pulse after the final row write.

Behaviour:
- Reset values: coeff_ready_o=0, we_o=0, waddr_o=0, din_o=0, busy_o=0, done_o=0; state IDLE; lane counter 0, row counter 0, pack register 0.
- Reset mid-operation: abandons the partial row with no write; the next start_i restarts at row 0, lane 0.
- State IDLE:
  - start_i=1 moves to FILL; busy_o=1 from the next cycle.
  - coeff_valid_i is ignored; coeff_ready_o=0.
- State FILL:
  - coeff_ready_o=1. A coefficient is accepted on any cycle with coeff_valid_i & coeff_ready_o.
  - Reduction: r = (coeff_i >= Q) ? coeff_i - Q : coeff_i. One conditional subtract is sufficient because coeff_i < 2Q.
  - r is stored in pack lane `lane`, then lane increments.
  - On the accept with lane==15: the full row (including this r) is copied into din_o, waddr_o=row, and we_o=1 on the following cycle only; lane wraps to 0 and row increments.
  - coeff_ready_o stays high through row boundaries, giving 1 coefficient/cycle sustained throughput with no bubbles.
  - din_o and waddr_o hold their values until the next row write.
  - Gaps in coeff_valid_i stall packing; no timeout.
- Final row: after the accept that completes row N_ROWS-1, state becomes DONE and coeff_ready_o drops the next cycle.
  - Cycle +1: we_o=1, waddr_o=N_ROWS-1.
  - Cycle +2: done_o=1, busy_o=0, state returns to IDLE, row counter resets to 0.
- Latency: row write strobe appears 1 cycle after its 16th accept; done_o appears 2 cycles after the final accept.
- start_i while busy_o=1 is ignored.
- start_i on the done_o cycle is accepted: loading restarts at row 0.
- we_o is never asserted outside a completed row; no partial rows are ever written.

Decomposition:
- Shared package ntt_pkg holds Q, WIDTH, LANES=16, N_ROWS, and the loader state enum (IDLE, FILL, DONE).
- One sub-module: mod_q_csub, a combinational conditional subtract (WIDTH in, WIDTH out, parameter Q).
- Packing, counters and FSM stay in the top module.

Test Plan:
- Reset then start; stream 0..255 back-to-back with valid held high:
  - 16 we_o pulses with waddr 0..15 at a spacing of exactly 16 cycles;
  - row 0 din_o lane k = k;
  - done_o 2 cycles after the last accept; coeff_ready_o never drops mid-stream.
- Reduction boundaries: coeff 3328 -> 3328, 3329 -> 0, 4095 -> 766, 0 -> 0, each checked in its lane position.
- Throttled valid (random 50% duty): identical row contents and addresses to the back-to-back case; only the we_o timing shifts.
- rst_i asserted after 37 accepts:
  - rows 0-1 were written; no further we_o;
  - all outputs return to reset values the next cycle;
  - a restart writes from waddr 0.
- start_i pulsed mid-FILL has no effect; start_i on the done_o cycle starts a second polynomial with waddr 0.
- valid asserted while in IDLE: no accept, coeff_ready_o=0, no we_o.
